// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S master transceiver.
package i2s_pkg;

    // Ceiling log2 for deriving counter and slot widths from power-of-two dividers.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DEF_MCLK_DIV_LRCK = 256;
    localparam int DEF_MCLK_DIV_SCLK = 4;
    localparam int DEF_PDATA_WIDTH   = 32;

    localparam int SLOT_BITS = clog2(DEF_MCLK_DIV_SCLK);
    localparam int CNT_BITS  = clog2(DEF_MCLK_DIV_LRCK);
    localparam int SLOTS     = 2 * DEF_PDATA_WIDTH;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame counter, SCLK/LRCK generation and one-cycle event strobes.
// Strobes are decoded from the next counter value, so a strobe that is high
// in a cycle names the event that happens on the coming mclk edge.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV_LRCK = DEF_MCLK_DIV_LRCK,
    parameter int MCLK_DIV_SCLK = DEF_MCLK_DIV_SCLK,
    parameter int PDATA_WIDTH   = DEF_PDATA_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic lrck,
    output logic slot_start,
    output logic sclk_rise,
    output logic load_tx,
    output logic left_done,
    output logic right_done
);

    localparam int SB = clog2(MCLK_DIV_SCLK);
    localparam int CB = clog2(MCLK_DIV_LRCK);

    logic [CB-1:0] cnt;
    logic [CB-1:0] cnt_nxt;

    // Power-of-two frame length lets the counter wrap naturally.
    assign cnt_nxt = cnt + CB'(1);

    // Event decode against the value cnt is about to take.
    always_comb begin
        slot_start = (cnt_nxt[SB-1:0] == '0);
        sclk_rise  = (cnt_nxt[SB-1:0] == SB'(MCLK_DIV_SCLK / 2));
        load_tx    = (cnt_nxt == CB'(MCLK_DIV_SCLK));
        right_done = (cnt_nxt == CB'(MCLK_DIV_SCLK));
        left_done  = (cnt_nxt == CB'((PDATA_WIDTH + 1) * MCLK_DIV_SCLK));
    end

    // Counter plus clock outputs registered from the next count so they line up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
            lrck <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            sclk <= cnt_nxt[SB-1];
            lrck <= cnt_nxt[CB-1];
        end
    end

endmodule

// File: rtl/i2s.sv
// I2S (Philips) bus master: generates SCLK/LRCK from MCLK, serialises the
// parallel left/right pair and deserialises the incoming stream.
module i2s
    import i2s_pkg::*;
#(
    parameter int MCLK_DIV_LRCK = DEF_MCLK_DIV_LRCK,
    parameter int MCLK_DIV_SCLK = DEF_MCLK_DIV_SCLK,
    parameter int PDATA_WIDTH   = DEF_PDATA_WIDTH
) (
    input  logic                   mclk_in,
    input  logic                   arstn_in,
    output logic                   lrck_out,
    output logic                   sclk_out,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   sdata_out,
    input  logic [PDATA_WIDTH-1:0] pldata_in,
    input  logic [PDATA_WIDTH-1:0] prdata_in
);

    localparam int PW = PDATA_WIDTH;

    // Frame geometry must give exactly one bit slot per data bit.
    if ((MCLK_DIV_LRCK != 2 * PDATA_WIDTH * MCLK_DIV_SCLK) || (MCLK_DIV_SCLK < 2) ||
        ((1 << clog2(MCLK_DIV_SCLK)) != MCLK_DIV_SCLK) ||
        ((1 << clog2(MCLK_DIV_LRCK)) != MCLK_DIV_LRCK)) begin : g_cfg_err
        $error("i2s: MCLK_DIV_LRCK / MCLK_DIV_SCLK must equal 2*PDATA_WIDTH, both powers of two");
    end

    logic slot_start;
    logic sclk_rise;
    logic load_tx;
    logic left_done;
    logic right_done;

    logic [2*PW-1:0] tx_sr;
    logic [PW-1:0]   rx_sr;

    i2s_clkgen #(
        .MCLK_DIV_LRCK (MCLK_DIV_LRCK),
        .MCLK_DIV_SCLK (MCLK_DIV_SCLK),
        .PDATA_WIDTH   (PDATA_WIDTH)
    ) u_clkgen (
        .clk        (mclk_in),
        .rst_n      (arstn_in),
        .sclk       (sclk_out),
        .lrck       (lrck_out),
        .slot_start (slot_start),
        .sclk_rise  (sclk_rise),
        .load_tx    (load_tx),
        .left_done  (left_done),
        .right_done (right_done)
    );

    // Transmit: load at slot 1 (one-bit Philips delay), otherwise shift on every SCLK fall.
    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            tx_sr     <= '0;
            sdata_out <= 1'b0;
        end else if (load_tx) begin
            tx_sr     <= {pldata_in, prdata_in};
            sdata_out <= pldata_in[PW-1];
        end else if (slot_start) begin
            tx_sr     <= tx_sr << 1;
            sdata_out <= tx_sr[2*PW-2];
        end
    end

    // Receive: sample mid-slot on SCLK rise, MSB first.
    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            rx_sr <= '0;
        end else if (sclk_rise) begin
            rx_sr <= {rx_sr[PW-2:0], sdata_in};
        end
    end

    // Parallel outputs capture a full word once its last bit has been sampled.
    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            pldata_out <= '0;
            prdata_out <= '0;
        end else begin
            if (left_done)  pldata_out <= rx_sr;
            if (right_done) prdata_out <= rx_sr;
        end
    end

endmodule

// File: tb/tb_i2s.sv
// Self-checking bench for the I2S master: a slot-level behavioural model
// predicts every output on every MCLK falling edge.
module tb_i2s;

    localparam int PW = 32;
    localparam int DL = 256;
    localparam int DS = 4;

    logic          mclk_in = 1'b0;
    logic          arstn_in;
    logic          lrck_out;
    logic          sclk_out;
    logic          sdata_in;
    logic [PW-1:0] pldata_out;
    logic [PW-1:0] prdata_out;
    logic          sdata_out;
    logic [PW-1:0] pldata_in;
    logic [PW-1:0] prdata_in;

    logic lb;
    logic rnd_bit;

    // Loopback or random serial input.
    assign sdata_in = lb ? sdata_out : rnd_bit;

    i2s #(
        .MCLK_DIV_LRCK (DL),
        .MCLK_DIV_SCLK (DS),
        .PDATA_WIDTH   (PW)
    ) dut (
        .mclk_in    (mclk_in),
        .arstn_in   (arstn_in),
        .lrck_out   (lrck_out),
        .sclk_out   (sclk_out),
        .sdata_in   (sdata_in),
        .pldata_out (pldata_out),
        .prdata_out (prdata_out),
        .sdata_out  (sdata_out),
        .pldata_in  (pldata_in),
        .prdata_in  (prdata_in)
    );

    always #10 mclk_in = ~mclk_in;

    // Model state: position in frame, words on the wire, received slot bits.
    int            c;
    int            frame;
    int            mode;
    logic [PW-1:0] cur_l;
    logic [PW-1:0] cur_r;
    logic [PW-1:0] exp_l;
    logic [PW-1:0] exp_r;
    logic [2*PW-1:0] rxbits;
    int            checks = 0;
    int            errors = 0;

    // Bit on the wire in a given frame position (Philips one-bit delay).
    function automatic logic exp_sd(input int cc);
        int b;
        b = cc / DS;
        if (b == 0) return cur_r[0];
        if (b <= PW) return cur_l[PW-b];
        return cur_r[2*PW-b];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s frame=%0d cnt=%0d actual=%h expected=%h", name, frame, c, act, exp);
        end
    endtask

    // One MCLK cycle: advance model, compare, drive, record.
    task automatic step();
        @(negedge mclk_in);
        if (!arstn_in) begin
            c = 0; frame = 1;
            cur_l = '0; cur_r = '0; exp_l = '0; exp_r = '0; rxbits = '0;
        end else begin
            c = (c + 1) % DL;
            if (c == 0) frame++;
            if (c == (PW + 1) * DS)
                for (int i = 1; i <= PW; i++) exp_l[PW-i] = rxbits[i];
            if (c == DS) begin
                for (int i = PW + 1; i < 2 * PW; i++) exp_r[2*PW-i] = rxbits[i];
                exp_r[0] = rxbits[0];
            end
        end
        chk("sclk", 32'(sclk_out), 32'((c % DS) >= DS / 2));
        chk("lrck", 32'(lrck_out), 32'(c >= DL / 2));
        chk("sdata_out", 32'(sdata_out), 32'(exp_sd(c)));
        chk("pldata_out", pldata_out, exp_l);
        chk("prdata_out", prdata_out, exp_r);
        if (mode == 0) begin
            rnd_bit = 1'($urandom);
            if ($urandom_range(0, 19) == 0) pldata_in = $urandom;
            if ($urandom_range(0, 19) == 0) prdata_in = $urandom;
        end else if (mode == 3 && arstn_in && c == DL / 2) begin
            pldata_in = pldata_in + 1;
        end
        if (arstn_in && (c % DS) == 1) rxbits[c/DS] = lb ? exp_sd(c) : rnd_bit;
        if (arstn_in && c == DS - 1) begin
            cur_l = pldata_in;
            cur_r = prdata_in;
        end
    endtask

    task automatic do_reset(input int n);
        arstn_in = 1'b0;
        repeat (n) step();
        arstn_in = 1'b1;
    endtask

    initial begin
        arstn_in  = 1'b0;
        lb        = 1'b1;
        rnd_bit   = 1'b0;
        mode      = 1;
        c         = 0;
        frame     = 1;
        pldata_in = 32'hA5A5_0001;
        prdata_in = 32'h8000_0001;

        // Fixed loopback with literal latency pins.
        do_reset(2);
        repeat (3 * DL) begin
            step();
            if (frame == 1 && c == 131) chk("lb_left_before", pldata_out, 32'h0);
            if (frame == 1 && c == 132) chk("lb_left", pldata_out, 32'hA5A5_0001);
            if (frame == 2 && c == 3)   chk("lb_right_before", prdata_out, 32'h0);
            if (frame == 2 && c == 4)   chk("lb_right", prdata_out, 32'h8000_0001);
            if (frame == 3 && c == 200) chk("lb_left_hold", pldata_out, 32'hA5A5_0001);
        end

        // Single-bit serial pattern: high only in slot 1.
        pldata_in = 32'h8000_0000;
        prdata_in = 32'h0;
        do_reset(1);
        repeat (3 * DL) begin
            step();
            chk("serial_slot1", 32'(sdata_out), 32'(c >= 4 && c <= 7));
        end

        // Incrementing left word, one step per frame.
        mode      = 3;
        pldata_in = 32'h0;
        prdata_in = 32'h0;
        do_reset(1);
        repeat (6 * DL) begin
            step();
            if (c == 132) begin
                chk("inc_left", pldata_out, 32'(frame - 1));
                chk("inc_right", prdata_out, 32'h0);
            end
        end

        // Mid-frame reset with nonzero outputs.
        while (c != 100) step();
        chk("pre_rst_nonzero", 32'(pldata_out != 0), 32'h1);
        arstn_in = 1'b0;
        #1;
        chk("rst_pl", pldata_out, 32'h0);
        chk("rst_sd", 32'({sdata_out, sclk_out, lrck_out}), 32'h0);
        mode      = 1;
        pldata_in = 32'h1234_5678;
        prdata_in = 32'h9ABC_DEF0;
        repeat (3) step();
        arstn_in = 1'b1;
        repeat (3 * DL) begin
            step();
            if (frame == 2 && c == 200) begin
                chk("recover_left", pldata_out, 32'h1234_5678);
                chk("recover_right", prdata_out, 32'h9ABC_DEF0);
            end
        end

        // Random words and random serial input, then random words in loopback.
        mode = 0;
        lb   = 1'b0;
        do_reset(1);
        repeat (4 * DL) step();
        lb = 1'b1;
        repeat (4 * DL) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
